// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - registered 8-phase sequencer for the accumulator CPU
// Optional macro SEQ_BUS_TIMEOUT_EN: adds the wait-state timeout counter and the ERROR state.
module cpu_phase_sequencer #(
  parameter int RETIRE_W = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic                halt_in,
  input  logic                rd,
  input  logic                wr,
  input  logic                mem_ready,
  output logic [2:0]          phase,
  output logic                running,
  output logic                stalled,
  output logic                halted,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic                bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_PAUSE,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [2:0] phase_d;
  logic       retire_d;
  logic       do_advance;
  logic       adv;
  logic       timeout_hit;

  // A phase may advance when no memory access is pending or the pending one is acknowledged
  assign adv = !(rd | wr) | mem_ready;

`ifdef SEQ_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == TIMEOUT_CNT);
  assign bus_err     = (state == S_ERROR);

  // Consecutive-wait counter: 1 on the stalling RUN cycle, +1 per unresolved WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == S_RUN && !adv) begin
      wait_cnt <= 8'd1;
    end else if (state == S_WAIT && !mem_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign running = (state == S_RUN) || (state == S_WAIT);
  assign stalled = (state == S_WAIT);
  assign halted  = (state == S_HALTED);

  // Next-state, next-phase and retire decision; WAIT resolving with mem_ready reuses the RUN advance path
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    retire_d   = 1'b0;
    do_advance = 1'b0;

    unique case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d = S_RUN;
          phase_d = 3'd0;
        end
      end
      S_RUN: begin
        if (adv) begin
          do_advance = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          do_advance = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_PAUSE: begin
        if (step || !step_mode) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
      end
    endcase

    if (do_advance) begin
      state_d = S_RUN;
      phase_d = phase + 3'd1;
      if (phase == 3'd4 && halt_in) begin
        // The halting instruction retires but the phase stays parked on 4
        state_d  = S_HALTED;
        phase_d  = phase;
        retire_d = 1'b1;
      end else if (phase == 3'd7) begin
        retire_d = 1'b1;
        if (step_mode) begin
          state_d = S_PAUSE;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Phase, one-cycle retire pulse and saturating retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 3'd0;
      retire     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      phase  <= phase_d;
      retire <= retire_d;
      if (retire_d && (retire_cnt != {RETIRE_W{1'b1}})) begin
        retire_cnt <= retire_cnt + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
Registered phase sequencer for the 8-phase accumulator CPU. It generates the 3-bit phase that drives the combinational phase/opcode controller. It handles:
- start/halt lifecycle
- single-step execution
- memory wait states, stalling the phase while a controller-issued rd/wr is not acknowledged
- a bus-timeout error
- counting retired instructions

Parameters:
RETIRE_W, 16, width of retired-instruction counter (saturating)
TIMEOUT, 15, max consecutive wait cycles before bus error (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start/restart pulse; honoured only in IDLE, HALTED, ERROR
step_mode  input  1  1 = pause after every instruction
step  input  1  release one instruction while paused
halt_in  input  1  halt from controller (valid in phase 3'b100)
rd  input  1  controller memory read request
wr  input  1  controller memory write request
mem_ready  input  1  memory acknowledge for current rd/wr
phase  output  3  current phase to controller
running  output  1  state is RUN or WAIT
stalled  output  1  state is WAIT
halted  output  1  state is HALTED
retire  output  1  one-cycle pulse per completed instruction
retire_cnt  output  RETIRE_W  retired-instruction count
bus_err  output  1  sticky bus-timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; phase=0; retire=0; retire_cnt=0; bus_err=0; wait counter=0. All outputs are registered or decoded from state. No glitch on deassertion; the first transition happens on the first clk edge after rst_n=1.
- States: IDLE, RUN, WAIT, PAUSE, HALTED, ERROR.
- IDLE: phase held at 0. start=1 -> RUN; phase 0 is presented for its first full cycle in RUN.
- RUN, advance condition is adv = !(rd|wr) | mem_ready:
  - adv=1: phase <= phase+1 mod 8.
  - adv=0: go to WAIT, phase held, wait counter cleared to 1.
- Instruction boundary: an advance from phase 7 to 0.
  - retire=1 for the next cycle only.
  - retire_cnt increments, saturating at all-ones.
  - If step_mode=1 at that edge, go to PAUSE with phase=0.
- Halt: in RUN with phase==3'b100, halt_in=1 and adv=1:
  - go to HALTED, phase held at 3'b100.
  - retire pulse fires and retire_cnt increments; the halt instruction counts.
- HALTED: halted=1. start=1 -> RUN with phase=0. Other inputs ignored.
- WAIT: phase held; wait counter increments each cycle.
  - mem_ready=1 -> return to RUN and advance the phase on the same edge; the phase 7 boundary rules apply.
  - Counter reaching TIMEOUT with mem_ready=0 -> ERROR (see optional feature).
- PAUSE: phase held at 0. step=1 -> RUN for exactly one instruction, provided step_mode is still 1. If step_mode=0 when step arrives, or step_mode drops while paused, -> RUN and free-run.
- ERROR: bus_err=1 (sticky); phase held. start=1 -> RUN, phase=0, bus_err cleared.
- Simultaneous events:
  - start is ignored in RUN, WAIT and PAUSE.
  - step is ignored outside PAUSE.
  - mem_ready and timeout in the same cycle: mem_ready wins.
  - halt_in with adv=0: the stall takes precedence; halt is re-evaluated when phase 4 advances.
- step_mode changes take effect only at an instruction boundary, or in PAUSE.
- Reset mid-operation (any state, including WAIT) returns immediately to IDLE. retire_cnt and bus_err are cleared.

Optional Feature:
Macro SEQ_BUS_TIMEOUT_EN.
- Defined: wait counter (8 bits) and ERROR state are present; a timeout after TIMEOUT consecutive WAIT cycles -> ERROR, bus_err=1.
- Undefined: no wait counter; WAIT persists until mem_ready; ERROR is unreachable; bus_err is tied to 0.

Test Plan:
- Reset then start pulse, rd=wr=0, halt_in=0 -> phase sequence 0,1,...,7,0 on consecutive cycles. retire pulses once per 8 cycles; retire_cnt=2 after 16 RUN cycles.
- Opcode-halt flow: halt_in=1 while phase=4 -> halted=1 next cycle, phase stays 4, retire_cnt=1. A second start -> phase=0, running=1.
- Wait state: rd=1 in phase 1 with mem_ready=0 for 3 cycles, then 1 -> phase holds at 1 for 3 cycles with stalled=1, then advances to 2. Total instruction time is 11 cycles.
- Timeout (macro defined, TIMEOUT=15): rd=1, mem_ready=0 held -> ERROR and bus_err=1 after 15 wait cycles, phase frozen. start -> bus_err=0, phase=0. With the macro undefined, the same stimulus stays in WAIT indefinitely and bus_err=0.
- Single step: step_mode=1, start -> one instruction runs, PAUSE with phase=0 and retire_cnt=1. Each step pulse -> exactly 8 more phases. step_mode=0 plus step -> free run.
- Async reset asserted during WAIT at phase 5 -> phase=0, state IDLE, retire_cnt=0 immediately, without waiting for a clock edge.
